busca_instrucao: RTL and testbench
==================================

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter LARGURA_END, default 8: ROM address width.
REQ-002 SHALL have parameter PROFUNDIDADE, default 32: number of ROM words; must be a power of 2 and no greater than 2^LARGURA_END.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port iniciar, input, 1 bit: start fetching from the current PC.
REQ-006 SHALL have port parar, input, 1 bit: stop fetching after the current handoff.
REQ-007 SHALL have port salto, input, 1 bit: single-cycle jump request.
REQ-008 SHALL have port endereco_salto, input, LARGURA_END bits: jump target.
REQ-009 SHALL have port ler_endereco, output, LARGURA_END bits: address to the ROM, equal to the PC.
REQ-010 SHALL have port instrucao_in, input, 8 bits: ROM data, combinational in ler_endereco.
REQ-011 SHALL have port instrucao, output, 8 bits: registered instruction to the decoder.
REQ-012 SHALL have port valido, output, 1 bit: instrucao holds an instruction not yet accepted.
REQ-013 SHALL have port pronto, input, 1 bit: decoder accepts instrucao when valido=1 and pronto=1.
REQ-014 SHALL have port ocupado, output, 1 bit: high in every state except OCIOSO.

Function
REQ-015 SHALL implement the states OCIOSO, BUSCA and VALIDO.
REQ-016 SHALL go from OCIOSO to BUSCA when iniciar=1; other inputs, except salto (REQ-022), have no effect in OCIOSO.
REQ-017 In BUSCA, SHALL on the clock edge latch instrucao_in into instrucao, advance the PC per REQ-020, set valido=1 and go to VALIDO; first instruction therefore appears 1 cycle after entering BUSCA.
REQ-018 In VALIDO with pronto=0, SHALL hold instrucao, valido and the PC stable.
REQ-019 In VALIDO with pronto=1 and parar=0, SHALL latch the next ROM word and advance the PC in the same edge, keeping valido=1, giving one instruction per cycle.
REQ-020 SHALL advance the PC as (PC+1) mod PROFUNDIDADE, so the word after PROFUNDIDADE-1 is 0.
REQ-021 In VALIDO with pronto=1 and parar=1, SHALL complete the handoff, clear valido and go to OCIOSO without advancing the PC.
REQ-022 When salto=1 (feature enabled), SHALL load the PC with endereco_salto mod PROFUNDIDADE, clear valido (discarding the unaccepted instruction) and go to BUSCA; salto in OCIOSO only loads the PC.
REQ-023 Priority, highest first: salto, then parar, then pronto; salto together with an accepted handoff still counts that handoff as delivered.
REQ-024 parar in BUSCA SHALL be remembered and honoured at the next accepted handoff.

Reset
REQ-025 With reset=0, SHALL immediately set the PC=0, instrucao=8'h00, valido=0, ocupado=0 and the state to OCIOSO, aborting any fetch or pending handoff.
REQ-026 SHALL leave reset synchronously to clk; the first state change is possible on the first rising edge after reset=1.

Configuration
REQ-027 With macro BUSCA_INSTRUCAO_SALTO_EN defined, SHALL implement salto per REQ-022 and REQ-023.
REQ-028 Without BUSCA_INSTRUCAO_SALTO_EN, salto and endereco_salto SHALL remain ports but be ignored; the PC changes only via REQ-020 and reset.

Verification
REQ-029 ROM words 0..3 = 01,02,03,04, iniciar pulse, pronto=1 -> instrucao 01,02,03,04 on consecutive cycles, valido=1 continuously from the cycle after BUSCA.
REQ-030 pronto=0 for 3 cycles while instrucao=02 -> instrucao=02, valido=1 and ler_endereco=2 held stable; resumes with 03 when pronto=1.
REQ-031 PC=31, pronto=1 -> ler_endereco goes 31 then 0; the instruction after word 31 is word 0.
REQ-032 Macro defined, salto=1, endereco_salto=8'd34 while valido=1, pronto=0 -> held instruction dropped (valido=0), next cycle instrucao=word 2, valido=1; macro undefined -> sequence unchanged.
REQ-033 parar=1 with pronto=1 on word 1 -> valido=0, ocupado=0 next cycle; iniciar later -> resumes at word 2.
REQ-034 reset=0 asynchronously mid-VALIDO -> instrucao=00, valido=0, ler_endereco=0 before the next clock edge.

Source files
------------

// File: rtl/busca_instrucao_if.sv
// busca_instrucao_if -- bus between the instruction fetch unit, its ROM and the decoder.
//
// Signals:
//   iniciar, parar        fetch start / stop requests
//   salto, endereco_salto single-cycle jump request and target
//   ler_endereco          ROM address (equals the PC)
//   instrucao_in          ROM data, combinational in ler_endereco
//   instrucao, valido     registered instruction and its valid flag to the decoder
//   pronto                decoder ready; a handoff happens when valido and pronto are both high
//   ocupado               fetch unit is not idle
//
// Modports:
//   slave  -- the fetch unit (busca_instrucao)
//   master -- the surrounding system (control, ROM and decoder side)
interface busca_instrucao_if #(
    parameter int unsigned LARGURA_END = 8
);
    logic                   iniciar;
    logic                   parar;
    logic                   salto;
    logic [LARGURA_END-1:0] endereco_salto;
    logic [LARGURA_END-1:0] ler_endereco;
    logic [7:0]             instrucao_in;
    logic [7:0]             instrucao;
    logic                   valido;
    logic                   pronto;
    logic                   ocupado;

    modport slave (
        input  iniciar,
        input  parar,
        input  salto,
        input  endereco_salto,
        input  instrucao_in,
        input  pronto,
        output ler_endereco,
        output instrucao,
        output valido,
        output ocupado
    );

    modport master (
        output iniciar,
        output parar,
        output salto,
        output endereco_salto,
        output instrucao_in,
        output pronto,
        input  ler_endereco,
        input  instrucao,
        input  valido,
        input  ocupado
    );
endinterface

// File: rtl/busca_instrucao.sv
// busca_instrucao -- instruction fetch unit.
//
// Walks a ROM of PROFUNDIDADE words (PC wraps modulo PROFUNDIDADE), registers each word into
// instrucao and hands it to the decoder with a valido/pronto handshake, one instruction per
// cycle while the decoder keeps pronto high.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    busca_instrucao_if.slave (control, ROM and decoder signals)
//
// Parameters:
//   LARGURA_END   ROM address width
//   PROFUNDIDADE  ROM depth; power of 2, at most 2**LARGURA_END
//
// Configuration:
//   BUSCA_INSTRUCAO_SALTO_EN  when defined, salto/endereco_salto load the PC and restart the
//                             fetch; when undefined both are ignored.
module busca_instrucao #(
    parameter int unsigned LARGURA_END  = 8,
    parameter int unsigned PROFUNDIDADE = 32
) (
    input logic              clk,
    input logic              reset,
    busca_instrucao_if.slave bus
);

    localparam logic [LARGURA_END-1:0] Mascara = LARGURA_END'(PROFUNDIDADE - 1);

    typedef enum logic [1:0] {
        StOcioso,
        StBusca,
        StValido
    } estado_e;

    estado_e                estado_q, estado_d;
    logic [LARGURA_END-1:0] pc_q, pc_d;
    logic [7:0]             instr_q, instr_d;
    logic                   valido_q, valido_d;
    // A parar seen before the handoff it applies to.
    logic                   parar_pend_q, parar_pend_d;

    logic [LARGURA_END-1:0] pc_inc;
    logic                   parar_efetivo;
    logic                   salto_ativo;
    logic [LARGURA_END-1:0] pc_salto;

    assign pc_inc        = (pc_q + LARGURA_END'(1)) & Mascara;
    assign parar_efetivo = bus.parar | parar_pend_q;

`ifdef BUSCA_INSTRUCAO_SALTO_EN
    assign salto_ativo = bus.salto;
    assign pc_salto    = bus.endereco_salto & Mascara;
`else
    logic unused_salto;
    assign unused_salto = ^{bus.salto, bus.endereco_salto};
    assign salto_ativo  = 1'b0;
    assign pc_salto     = '0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q     <= StOcioso;
            pc_q         <= '0;
            instr_q      <= 8'h00;
            valido_q     <= 1'b0;
            parar_pend_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            valido_q     <= valido_d;
            parar_pend_q <= parar_pend_d;
        end
    end

    // Next state; salto outranks parar, which outranks a plain handoff.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StOcioso: begin
                if (bus.iniciar) estado_d = StBusca;
            end
            StBusca: begin
                if (!salto_ativo) estado_d = StValido;
            end
            StValido: begin
                if (salto_ativo) begin
                    estado_d = StBusca;
                end else if (bus.pronto && parar_efetivo) begin
                    estado_d = StOcioso;
                end
            end
            default: estado_d = StOcioso;
        endcase
    end

    // Datapath updates and outputs.
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        valido_d     = valido_q;
        parar_pend_d = parar_pend_q;
        unique case (estado_q)
            StOcioso: begin
                if (salto_ativo) pc_d = pc_salto;
            end
            StBusca: begin
                if (salto_ativo) begin
                    pc_d = pc_salto;
                end else begin
                    instr_d  = bus.instrucao_in;
                    pc_d     = pc_inc;
                    valido_d = 1'b1;
                    if (bus.parar) parar_pend_d = 1'b1;
                end
            end
            StValido: begin
                if (salto_ativo) begin
                    // Unaccepted instruction is discarded; refetch from the target.
                    pc_d     = pc_salto;
                    valido_d = 1'b0;
                end else if (bus.pronto) begin
                    if (parar_efetivo) begin
                        // PC already points at the next word, so a later iniciar resumes there.
                        valido_d     = 1'b0;
                        parar_pend_d = 1'b0;
                    end else begin
                        instr_d = bus.instrucao_in;
                        pc_d    = pc_inc;
                    end
                end else if (bus.parar) begin
                    parar_pend_d = 1'b1;
                end
            end
            default: begin
                valido_d     = 1'b0;
                parar_pend_d = 1'b0;
            end
        endcase
    end

    assign bus.ler_endereco = pc_q;
    assign bus.instrucao    = instr_q;
    assign bus.valido       = valido_q;
    assign bus.ocupado      = (estado_q != StOcioso);

endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao -- self-checking bench for busca_instrucao with a transaction-level model.
module tb_busca_instrucao;

    localparam int unsigned LarguraEnd   = 8;
    localparam int unsigned Profundidade = 32;
`ifdef BUSCA_INSTRUCAO_SALTO_EN
    localparam bit SaltoEn = 1'b1;
`else
    localparam bit SaltoEn = 1'b0;
`endif

    logic clk;
    logic reset;
    logic [7:0] rom [256];

    busca_instrucao_if #(.LARGURA_END(LarguraEnd)) bus ();

    busca_instrucao #(
        .LARGURA_END (LarguraEnd),
        .PROFUNDIDADE(Profundidade)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.instrucao_in = rom[bus.ler_endereco];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a running/fetching/holding view of the fetch unit.
    int       m_pc;
    logic [7:0] m_instr;
    bit       m_valido;
    bit       m_ativo;
    bit       m_buscando;
    bit       m_parar_pend;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelo_reset();
        m_pc         = 0;
        m_instr      = 8'h00;
        m_valido     = 1'b0;
        m_ativo      = 1'b0;
        m_buscando   = 1'b0;
        m_parar_pend = 1'b0;
    endtask

    task automatic modelo_passo(input bit ini, input bit par, input bit sal,
                                input logic [7:0] alvo, input bit pro);
        if (SaltoEn && sal) begin
            m_pc = int'(alvo) % Profundidade;
            if (m_ativo) begin
                m_valido   = 1'b0;
                m_buscando = 1'b1;
            end else if (ini) begin
                m_ativo    = 1'b1;
                m_buscando = 1'b1;
            end
        end else if (!m_ativo) begin
            if (ini) begin
                m_ativo    = 1'b1;
                m_buscando = 1'b1;
            end
        end else if (m_buscando) begin
            m_instr    = rom[m_pc];
            m_pc       = (m_pc + 1) % Profundidade;
            m_valido   = 1'b1;
            m_buscando = 1'b0;
            if (par) m_parar_pend = 1'b1;
        end else if (pro) begin
            if (par || m_parar_pend) begin
                m_valido     = 1'b0;
                m_ativo      = 1'b0;
                m_parar_pend = 1'b0;
            end else begin
                m_instr = rom[m_pc];
                m_pc    = (m_pc + 1) % Profundidade;
            end
        end else if (par) begin
            m_parar_pend = 1'b1;
        end
    endtask

    task automatic comparar();
        check_eq("ler_endereco", 32'(bus.ler_endereco), 32'(m_pc));
        check_eq("instrucao", 32'(bus.instrucao), 32'(m_instr));
        check_eq("valido", 32'(bus.valido), 32'(m_valido));
        check_eq("ocupado", 32'(bus.ocupado), 32'(m_ativo));
    endtask

    // Called just after a falling edge: drive, clock, update model, check at the next falling edge.
    task automatic ciclo(input bit ini, input bit par, input bit sal,
                         input logic [7:0] alvo, input bit pro);
        bus.iniciar        = ini;
        bus.parar          = par;
        bus.salto          = sal;
        bus.endereco_salto = alvo;
        bus.pronto         = pro;
        @(posedge clk);
        modelo_passo(ini, par, sal, alvo, pro);
        @(negedge clk);
        comparar();
    endtask

    // Asynchronous reset between edges; outputs must clear before the next rising edge.
    task automatic reset_assincrono();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_ler_endereco", 32'(bus.ler_endereco), 32'd0);
        check_eq("rst_instrucao", 32'(bus.instrucao), 32'd0);
        check_eq("rst_valido", 32'(bus.valido), 32'd0);
        check_eq("rst_ocupado", 32'(bus.ocupado), 32'd0);
        modelo_reset();
        @(posedge clk);
        @(negedge clk);
        comparar();
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h01;
        rom[1] = 8'h02;
        rom[2] = 8'h03;
        rom[3] = 8'h04;

        reset              = 1'b0;
        bus.iniciar        = 1'b1;
        bus.parar          = 1'b0;
        bus.salto          = 1'b0;
        bus.endereco_salto = 8'd0;
        bus.pronto         = 1'b1;
        modelo_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_ler_endereco", 32'(bus.ler_endereco), 32'd0);
        check_eq("reset_instrucao", 32'(bus.instrucao), 32'd0);
        check_eq("reset_valido", 32'(bus.valido), 32'd0);
        check_eq("reset_ocupado", 32'(bus.ocupado), 32'd0);
        reset = 1'b1;

        // Start, stream 01,02 then stall three cycles on 02, then 03,04.
        ciclo(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        check_eq("primeira_instrucao", 32'(bus.instrucao), 32'h01);
        ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        repeat (3) ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        check_eq("espera_instrucao", 32'(bus.instrucao), 32'h02);
        check_eq("espera_endereco", 32'(bus.ler_endereco), 32'd2);
        ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        check_eq("retoma_instrucao", 32'(bus.instrucao), 32'h03);
        ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

        // Run across the wrap from word 31 to word 0.
        repeat (30) ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        check_eq("volta_instrucao", 32'(bus.instrucao), 32'(rom[1]));

        // Stop on a handoff, then resume.
        ciclo(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        check_eq("parar_ocupado", 32'(bus.ocupado), 32'd0);
        repeat (2) ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        ciclo(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // Jump to 34 (word 2) while holding an unaccepted instruction.
        ciclo(1'b0, 1'b0, 1'b1, 8'd34, 1'b0);
        ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

        // Asynchronous reset mid-stream.
        ciclo(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        reset_assincrono();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_assincrono();
            end else begin
                ciclo($urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 11) == 0,
                      8'($urandom),
                      $urandom_range(0, 9) < 6);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
